ac97_codec_link: RTL
====================

# ac97_codec_link

Codec-side endpoint of the AC-link serial interface, clocked by the link bit clock. It deframes the controller's SYNC/SDATA_OUT stream into DAC samples and register read/write commands, and serialises ADC samples and register-read replies onto SDATA_IN. It serves as a synthesizable codec model for loopback testing of the AC97 controller, and as a codec front end for FPGA-to-FPGA audio links.

## Interface
- SAMPLE_W, 18, PCM sample width; 1..20; samples are MSB-justified in 20-bit slots.
- clk  in  1  AC-link bit clock; one cycle = one bit time.
- reset  in  1  synchronous, active-high.
- ac97_sync  in  1  frame sync from controller.
- ac97_sdata_out  in  1  controller-to-codec serial data, MSB first.
- ac97_sdata_in  out  1  codec-to-controller serial data, MSB first.
- codec_ready  in  1  reported in the outgoing tag bit 15.
- adc_l, adc_r  in  SAMPLE_W  capture samples, sampled at frame bit 0.
- adc_strobe  out  1  1-cycle pulse when adc_l/adc_r are captured.
- dac_l, dac_r  out  SAMPLE_W  last received playback samples.
- dac_valid  out  1  1-cycle pulse when dac_l and/or dac_r update.
- reg_wr_en, reg_rd_en  out  1  1-cycle command pulses.
- reg_addr  out  7  register index of the current command.
- reg_wdata  out  16  write data.
- reg_rdata  in  16  read data; sampled 1 cycle after reg_rd_en.
- frame_locked  out  1  high once a SYNC edge has been seen.
- sync_err  out  1  1-cycle pulse on a misaligned SYNC edge.

## Operation
- Frame: 256 bits. Slot 0 is the 16-bit tag. Slots 1..12 are 20 bits each; slot s starts at bit 16+20(s-1). Bit index b runs 0..255, with b=0 being tag bit 15.
- Sync detect: sync_q holds the previous ac97_sync. ac97_sync=1 with sync_q=0 marks a frame start: b:=0 in that cycle. Otherwise b increments mod 256, but only while frame_locked.
- Frame start sets frame_locked. If frame_locked was already 1 and b (pre-increment) != 255, pulse sync_err and realign.
- Receive: a shift register captures ac97_sdata_out every cycle. The tag is latched at b=15; bit 15 = frame valid, bits 14..3 = slots 1..12 valid.
- Command decode at b=55 (last bit of slot 2). Outputs assert in the b=56 cycle, and only if tag bit 15 and the slot 1 valid bit are set.
  - slot1[19]=0 with slot 2 valid: reg_wr_en=1, reg_addr=slot1[18:12], reg_wdata=slot2[19:4].
  - slot1[19]=1: reg_rd_en=1 and reg_addr=slot1[18:12]; slot 2 is ignored.
  - Otherwise: no pulse.
- Read reply:
  - reg_rdata is captured in the b=57 cycle, together with the address, and sets reply_pending.
  - At the next frame's b=0, reply_pending is transferred into the outgoing frame and cleared.
  - A second read before transfer overwrites the captured address/data; only one reply is sent.
- DAC decode at b=95 (last bit of slot 4), with outputs in the b=96 cycle:
  - dac_l := slot3[19:20-SAMPLE_W] if tag bit 15 and slot 3 valid are set.
  - dac_r likewise from slot 4.
  - dac_valid=1 if either updated; a non-updated channel holds its value.
- Transmit, fixed at b=0 of each frame:
  - adc_l/adc_r captured; adc_strobe=1 in that cycle.
  - Tag bit 15 = codec_ready; bits 14,13 = reply present; bits 12,11 = codec_ready; all other tag bits 0.
  - Slot 1 = {0, addr[6:0], 12'h000}; slot 2 = {rdata, 4'h0}. Both are zero if no reply.
  - Slots 3/4 = ADC samples, low bits zero-padded. Slots 5..12 = 0.
- Before frame_locked: ac97_sdata_in=0 and no pulses.

## Timing
- Output registered: ac97_sdata_in in the cycle after index b is frame bit b. Its value in the cycle after b=255 is the next frame's bit 0.
- Reset values: every output 0, dac_l/dac_r=0, reply_pending=0, frame_locked=0, b=0. Reset mid-frame discards all partial state; the next SYNC edge starts clean.
- Realign before b=55 means no command is emitted for the truncated frame; before b=95 means no DAC update. reply_pending survives realign.
- SYNC held high more than 16 bits is not an error; only rising edges count.
- ac97_sync asserted in the same cycle as reset is ignored.

## Test plan
- Lock: reset 4 cycles, then SYNC rising at t0 → frame_locked=1 at t0+1. Tag 0x9800 (codec_ready=1) appears on sdata_in bits 1..16 cycles after t0. adc_strobe pulses at t0.
- Write: frame with tag 0xE000, slot1=0x02000, slot2=0x80800 → reg_wr_en at b=56, reg_addr=0x02, reg_wdata=0x8080. No reg_rd_en.
- Read: tag 0xC000, slot1=0x9C000; reg_rdata=0x6A90 one cycle after reg_rd_en, with reg_addr=0x1C → next frame tag bits 14,13=1, slot1=0x1C000, slot2=0x6A900.
- DAC: SAMPLE_W=18, tag 0x9800, slot3=0xABCDC, slot4=0x12344 → dac_valid at b=96, dac_l=0x2AF37, dac_r=0x048D1. Tag 0x9000 in the next frame → dac_r unchanged, dac_l updated.
- ADC loopback: adc_l=0x3FFFF, adc_r=0x00001 → slot3 serialised 0xFFFFC, slot4 0x00004.
- Misalignment: SYNC edge at b=100 → sync_err pulse, b:=0. A truncated frame at b=40 yields no reg_*_en. A pending read reply is still sent in the following frame.

Source files
------------

// File: rtl/ac97_codec_link.sv
// rtl/ac97_codec_link.sv - AC-link codec endpoint: deframes SDATA_OUT, serialises SDATA_IN
// Frame bit index b runs 0..255; a SYNC rising edge forces b=0 in the same cycle.
module ac97_codec_link #(
  parameter int SAMPLE_W = 18
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ac97_sync,
  input  logic                ac97_sdata_out,
  output logic                ac97_sdata_in,
  input  logic                codec_ready,
  input  logic [SAMPLE_W-1:0] adc_l,
  input  logic [SAMPLE_W-1:0] adc_r,
  output logic                adc_strobe,
  output logic [SAMPLE_W-1:0] dac_l,
  output logic [SAMPLE_W-1:0] dac_r,
  output logic                dac_valid,
  output logic                reg_wr_en,
  output logic                reg_rd_en,
  output logic [6:0]          reg_addr,
  output logic [15:0]         reg_wdata,
  input  logic [15:0]         reg_rdata,
  output logic                frame_locked,
  output logic                sync_err
);
  localparam int PAD = 20 - SAMPLE_W;

  typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_t;
  state_t state, state_nx;

  logic         sync_q, frame_start, active;
  logic [7:0]   b_cnt, bi;
  logic [18:0]  rx;
  logic [19:0]  rx_now;
  logic [4:0]   tag_v;
  logic [7:0]   slot1_cmd;
  logic [19:0]  slot3;
  logic         rd_d, reply_pending;
  logic [6:0]   reply_addr;
  logic [15:0]  reply_data;
  logic [255:0] tx, tx_frame;
  logic [15:0]  tx_tag;
  logic [19:0]  tx_s1, tx_s2, tx_s3, tx_s4;

  assign rx_now       = {rx, ac97_sdata_out};
  assign frame_locked = (state == ST_LOCKED);

  always_comb begin
    state_nx    = state;
    sync_err    = 1'b0;
    frame_start = ac97_sync & ~sync_q & ~reset;
    if (frame_start) begin
      state_nx = ST_LOCKED;
      // an aligned edge arrives exactly when the counter has wrapped to 0
      if (state == ST_LOCKED && b_cnt != 8'd0) sync_err = 1'b1;
    end
    active     = ~reset & (frame_start | (state == ST_LOCKED));
    bi         = frame_start ? 8'd0 : b_cnt;
    adc_strobe = active & (bi == 8'd0);
  end

  always_comb begin
    tx_tag   = {codec_ready, reply_pending, reply_pending, codec_ready, codec_ready, 11'd0};
    tx_s1    = reply_pending ? {1'b0, reply_addr, 12'h000} : 20'd0;
    tx_s2    = reply_pending ? {reply_data, 4'h0} : 20'd0;
    tx_s3    = 20'(adc_l) << PAD;
    tx_s4    = 20'(adc_r) << PAD;
    tx_frame = {tx_tag, tx_s1, tx_s2, tx_s3, tx_s4, 160'd0};
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_UNLOCKED;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    // tracks SYNC through reset so a level held across reset is not an edge
    sync_q <= ac97_sync;
    if (reset) begin
      b_cnt         <= '0;
      rx            <= '0;
      tag_v         <= '0;
      slot1_cmd     <= '0;
      slot3         <= '0;
      rd_d          <= 1'b0;
      reply_pending <= 1'b0;
      reply_addr    <= '0;
      reply_data    <= '0;
      tx            <= '0;
      ac97_sdata_in <= 1'b0;
      dac_l         <= '0;
      dac_r         <= '0;
      dac_valid     <= 1'b0;
      reg_wr_en     <= 1'b0;
      reg_rd_en     <= 1'b0;
      reg_addr      <= '0;
      reg_wdata     <= '0;
    end else begin
      rx        <= rx_now[18:0];
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      dac_valid <= 1'b0;
      rd_d      <= reg_rd_en;
      if (active) begin
        b_cnt <= bi + 8'd1;
        case (bi)
          8'd15: tag_v     <= rx_now[15:11];
          8'd35: slot1_cmd <= rx_now[19:12];
          8'd55: begin
            if (tag_v[4] && tag_v[3]) begin
              if (slot1_cmd[7]) begin
                reg_rd_en <= 1'b1;
                reg_addr  <= slot1_cmd[6:0];
              end else if (tag_v[2]) begin
                reg_wr_en <= 1'b1;
                reg_addr  <= slot1_cmd[6:0];
                reg_wdata <= rx_now[19:4];
              end
            end
          end
          8'd75: slot3 <= rx_now;
          8'd95: begin
            if (tag_v[4] && tag_v[1]) dac_l <= SAMPLE_W'(slot3 >> PAD);
            if (tag_v[4] && tag_v[0]) dac_r <= SAMPLE_W'(rx_now >> PAD);
            dac_valid <= tag_v[4] & (tag_v[1] | tag_v[0]);
          end
          default: ;
        endcase
        if (bi == 8'd0) begin
          ac97_sdata_in <= tx_frame[255];
          tx            <= {tx_frame[254:0], 1'b0};
          reply_pending <= 1'b0;
        end else begin
          ac97_sdata_in <= tx[255];
          tx            <= {tx[254:0], 1'b0};
        end
      end else begin
        ac97_sdata_in <= 1'b0;
      end
      // read data is valid the cycle after reg_rd_en
      if (rd_d) begin
        reply_pending <= 1'b1;
        reply_addr    <= reg_addr;
        reply_data    <= reg_rdata;
      end
    end
  end
endmodule
